// File: rtl/snake_head_stepper_if.sv
// Bus between the direction/start controller and the snake head stepper.
// The controller side drives the direction, start and speed requests. The body
// stage supplies the kill flag, and the game shell supplies restart. The
// stepper returns the head position, the step pulse, the committed direction
// and the dead flag.
interface snake_head_stepper_if #(
    parameter int X_BITS = 5,
    parameter int Y_BITS = 4
);
    logic [1:0]        i_dir;
    logic              i_start;
    logic [1:0]        i_speed;
    logic              i_kill;
    logic              i_restart;
    logic [X_BITS-1:0] o_head_x;
    logic [Y_BITS-1:0] o_head_y;
    logic [1:0]        o_head_dir;
    logic              o_step;
    logic              o_dead;

    modport master (
        output i_dir, i_start, i_speed, i_kill, i_restart,
        input  o_head_x, o_head_y, o_head_dir, o_step, o_dead
    );

    modport slave (
        input  i_dir, i_start, i_speed, i_kill, i_restart,
        output o_head_x, o_head_y, o_head_dir, o_step, o_dead
    );
endinterface

// File: rtl/snake_head_stepper.sv
// Snake head movement stage. It generates the game tick from a programmable
// period and moves the head one cell per tick in the requested direction.
// A move off the grid either wraps to the opposite edge or kills the snake,
// depending on WRAP. A kill from the body stage always stops the snake.
module snake_head_stepper #(
    parameter int X_BITS      = 5,
    parameter int Y_BITS      = 4,
    parameter int GRID_W      = 32,
    parameter int GRID_H      = 16,
    parameter int START_X     = 16,
    parameter int START_Y     = 2,
    parameter int TICK_PERIOD = 1000000,
    parameter int WRAP        = 0
) (
    input logic                 clk,
    input logic                 rst_n,
    snake_head_stepper_if.slave bus
);
    localparam int CNT_W = $clog2(TICK_PERIOD + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [X_BITS:0]   X_ONE       = (X_BITS + 1)'(1);
    localparam logic [Y_BITS:0]   Y_ONE       = (Y_BITS + 1)'(1);
    localparam logic [X_BITS:0]   GRID_W_EXT  = (X_BITS + 1)'(GRID_W);
    localparam logic [Y_BITS:0]   GRID_H_EXT  = (Y_BITS + 1)'(GRID_H);
    localparam logic [X_BITS-1:0] X_MAX       = X_BITS'(GRID_W - 1);
    localparam logic [Y_BITS-1:0] Y_MAX       = Y_BITS'(GRID_H - 1);
    localparam logic [X_BITS-1:0] X_HOME      = X_BITS'(START_X);
    localparam logic [Y_BITS-1:0] Y_HOME      = Y_BITS'(START_Y);
    localparam logic [1:0]        DIR_UP      = 2'b00;
    localparam logic [1:0]        DIR_DOWN    = 2'b01;
    localparam logic [1:0]        DIR_LEFT    = 2'b10;
    localparam logic [1:0]        DIR_RIGHT   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CNT_W-1:0]  period, period_nxt;
    logic [X_BITS-1:0] head_x, head_x_nxt;
    logic [Y_BITS-1:0] head_y, head_y_nxt;
    logic [1:0]        head_dir, head_dir_nxt;
    logic              step, step_nxt;

    logic [X_BITS:0]   nx;
    logic [Y_BITS:0]   ny;
    logic              x_off, y_off;
    logic [X_BITS-1:0] x_tgt;
    logic [Y_BITS-1:0] y_tgt;
    logic              move_ok;

    // Tick period for a speed setting; each speed step halves the period.
    function automatic logic [CNT_W-1:0] period_for(input logic [1:0] speed);
        return CNT_W'(TICK_PERIOD >> speed);
    endfunction

    // Candidate cell one step away, in one extra bit so that under- and
    // overflow both show up as a value at or beyond the grid size.
    always_comb begin
        nx = {1'b0, head_x};
        ny = {1'b0, head_y};
        case (bus.i_dir)
            DIR_UP:    ny = {1'b0, head_y} - Y_ONE;
            DIR_DOWN:  ny = {1'b0, head_y} + Y_ONE;
            DIR_LEFT:  nx = {1'b0, head_x} - X_ONE;
            default:   nx = {1'b0, head_x} + X_ONE;
        endcase
        x_off = (nx >= GRID_W_EXT);
        y_off = (ny >= GRID_H_EXT);
        x_tgt = nx[X_BITS-1:0];
        y_tgt = ny[Y_BITS-1:0];
        if (x_off) begin
            x_tgt = (bus.i_dir == DIR_LEFT) ? X_MAX : '0;
        end
        if (y_off) begin
            y_tgt = (bus.i_dir == DIR_UP) ? Y_MAX : '0;
        end
        move_ok = !(x_off || y_off) || (WRAP != 0);
    end

    // Next-state and datapath update for the IDLE/RUN/DEAD controller.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        period_nxt   = period;
        head_x_nxt   = head_x;
        head_y_nxt   = head_y;
        head_dir_nxt = head_dir;
        step_nxt     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt    = '0;
                period_nxt = period_for(bus.i_speed);
                if (bus.i_start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.i_kill) begin
                    // A kill beats a coincident tick, so the head never moves.
                    state_nxt = DEAD;
                    cnt_nxt   = '0;
                end else if (cnt == period - CNT_ONE) begin
                    // The speed is sampled only at the wrap, so a speed change
                    // never cuts a tick short.
                    cnt_nxt    = '0;
                    period_nxt = period_for(bus.i_speed);
                    if (move_ok) begin
                        head_x_nxt   = x_tgt;
                        head_y_nxt   = y_tgt;
                        head_dir_nxt = bus.i_dir;
                        step_nxt     = 1'b1;
                    end else begin
                        state_nxt = DEAD;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            DEAD: begin
                cnt_nxt    = '0;
                period_nxt = period_for(bus.i_speed);
                if (bus.i_restart) begin
                    state_nxt    = IDLE;
                    head_x_nxt   = X_HOME;
                    head_y_nxt   = Y_HOME;
                    head_dir_nxt = DIR_DOWN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, tick counter and head registers with asynchronous reset to the
    // start cell, pointing down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            period   <= period_for(2'd0);
            head_x   <= X_HOME;
            head_y   <= Y_HOME;
            head_dir <= DIR_DOWN;
            step     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            period   <= period_nxt;
            head_x   <= head_x_nxt;
            head_y   <= head_y_nxt;
            head_dir <= head_dir_nxt;
            step     <= step_nxt;
        end
    end

    assign bus.o_head_x   = head_x;
    assign bus.o_head_y   = head_y;
    assign bus.o_head_dir = head_dir;
    assign bus.o_step     = step;
    assign bus.o_dead     = (state == DEAD);
endmodule

// File: tb/tb_snake_head_stepper.sv
// Bench for snake_head_stepper. It runs a wall-kill instance and a wrap
// instance side by side on the same inputs, through a table of timed vectors
// and then an asynchronous reset taken mid-run.
module tb_snake_head_stepper;
    logic clk;
    logic rst_n;

    snake_head_stepper_if #(.X_BITS(5), .Y_BITS(4)) bus0 ();
    snake_head_stepper_if #(.X_BITS(5), .Y_BITS(4)) bus1 ();

    snake_head_stepper #(
        .X_BITS(5), .Y_BITS(4), .GRID_W(32), .GRID_H(16),
        .START_X(16), .START_Y(2), .TICK_PERIOD(8), .WRAP(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    snake_head_stepper #(
        .X_BITS(5), .Y_BITS(4), .GRID_W(32), .GRID_H(16),
        .START_X(16), .START_Y(2), .TICK_PERIOD(8), .WRAP(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [1:0] dir;
        logic [1:0] speed;
        logic       kill;
        logic       restart;
        int         ncyc;
        int         x0, y0, dir0, step0, dead0;
        int         x1, y1, dir1, step1, dead1;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_bad;

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got %0d, expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic start, input logic [1:0] dir, input logic [1:0] speed,
                         input logic kill, input logic restart);
        bus0.i_start = start;   bus1.i_start = start;
        bus0.i_dir = dir;       bus1.i_dir = dir;
        bus0.i_speed = speed;   bus1.i_speed = speed;
        bus0.i_kill = kill;     bus1.i_kill = kill;
        bus0.i_restart = restart; bus1.i_restart = restart;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " d0 x"}, 0, int'(bus0.o_head_x), 16);
        chk({tag, " d0 y"}, 0, int'(bus0.o_head_y), 2);
        chk({tag, " d0 dir"}, 0, int'(bus0.o_head_dir), 1);
        chk({tag, " d0 step"}, 0, int'(bus0.o_step), 0);
        chk({tag, " d0 dead"}, 0, int'(bus0.o_dead), 0);
        chk({tag, " d1 x"}, 0, int'(bus1.o_head_x), 16);
        chk({tag, " d1 y"}, 0, int'(bus1.o_head_y), 2);
        chk({tag, " d1 dir"}, 0, int'(bus1.o_head_dir), 1);
        chk({tag, " d1 step"}, 0, int'(bus1.o_step), 0);
        chk({tag, " d1 dead"}, 0, int'(bus1.o_dead), 0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // start dir spd kill rst ncyc | d0: x y dir step dead | d1: x y dir step dead
        vecs.push_back('{1'b1, 2'b01, 2'd0, 1'b0, 1'b0,   8, 16, 2, 1, 0, 0, 16, 2, 1, 0, 0});
        vecs.push_back('{1'b1, 2'b01, 2'd0, 1'b0, 1'b0,   1, 16, 3, 1, 1, 0, 16, 3, 1, 1, 0});
        vecs.push_back('{1'b1, 2'b01, 2'd0, 1'b0, 1'b0,   1, 16, 3, 1, 0, 0, 16, 3, 1, 0, 0});
        vecs.push_back('{1'b1, 2'b01, 2'd0, 1'b0, 1'b0,   7, 16, 4, 1, 1, 0, 16, 4, 1, 1, 0});
        vecs.push_back('{1'b1, 2'b10, 2'd0, 1'b0, 1'b0,   8, 15, 4, 2, 1, 0, 15, 4, 2, 1, 0});
        vecs.push_back('{1'b1, 2'b10, 2'd0, 1'b0, 1'b0, 112,  1, 4, 2, 1, 0,  1, 4, 2, 1, 0});
        vecs.push_back('{1'b1, 2'b10, 2'd0, 1'b0, 1'b0,   8,  0, 4, 2, 1, 0,  0, 4, 2, 1, 0});
        vecs.push_back('{1'b1, 2'b10, 2'd0, 1'b0, 1'b0,   8,  0, 4, 2, 0, 1, 31, 4, 2, 1, 0});
        vecs.push_back('{1'b1, 2'b10, 2'd0, 1'b0, 1'b0,   8,  0, 4, 2, 0, 1, 30, 4, 2, 1, 0});
        vecs.push_back('{1'b0, 2'b10, 2'd0, 1'b0, 1'b1,   1, 16, 2, 1, 0, 0, 30, 4, 2, 0, 0});
        vecs.push_back('{1'b0, 2'b10, 2'd0, 1'b1, 1'b0,   1, 16, 2, 1, 0, 0, 30, 4, 2, 0, 1});
        vecs.push_back('{1'b0, 2'b10, 2'd0, 1'b0, 1'b1,   1, 16, 2, 1, 0, 0, 16, 2, 1, 0, 0});
        vecs.push_back('{1'b1, 2'b00, 2'd0, 1'b0, 1'b0,   9, 16, 1, 0, 1, 0, 16, 1, 0, 1, 0});
        vecs.push_back('{1'b1, 2'b11, 2'd0, 1'b0, 1'b0,   7, 16, 1, 0, 0, 0, 16, 1, 0, 0, 0});
        vecs.push_back('{1'b1, 2'b11, 2'd0, 1'b1, 1'b0,   1, 16, 1, 0, 0, 1, 16, 1, 0, 0, 1});
        vecs.push_back('{1'b1, 2'b11, 2'd0, 1'b0, 1'b0,   3, 16, 1, 0, 0, 1, 16, 1, 0, 0, 1});
        vecs.push_back('{1'b1, 2'b11, 2'd0, 1'b0, 1'b1,   1, 16, 2, 1, 0, 0, 16, 2, 1, 0, 0});
        vecs.push_back('{1'b1, 2'b00, 2'd0, 1'b0, 1'b0,   4, 16, 2, 1, 0, 0, 16, 2, 1, 0, 0});
        vecs.push_back('{1'b1, 2'b00, 2'd2, 1'b0, 1'b0,   4, 16, 2, 1, 0, 0, 16, 2, 1, 0, 0});
        vecs.push_back('{1'b1, 2'b00, 2'd2, 1'b0, 1'b0,   1, 16, 1, 0, 1, 0, 16, 1, 0, 1, 0});
        vecs.push_back('{1'b1, 2'b00, 2'd2, 1'b0, 1'b0,   1, 16, 1, 0, 0, 0, 16, 1, 0, 0, 0});
        vecs.push_back('{1'b1, 2'b00, 2'd2, 1'b0, 1'b0,   1, 16, 0, 0, 1, 0, 16, 0, 0, 1, 0});
        vecs.push_back('{1'b1, 2'b00, 2'd2, 1'b0, 1'b0,   2, 16, 0, 0, 0, 1, 16, 15, 0, 1, 0});

        // Asynchronous reset seen between clock edges, before any edge.
        rst_n = 1'b1;
        drive(1'b0, 2'b01, 2'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("reset");
        cyc();
        cyc();
        rst_n = 1'b1;

        // Timed vector table: hold the inputs for ncyc cycles, then compare.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].dir, vecs[i].speed, vecs[i].kill, vecs[i].restart);
            for (int c = 0; c < vecs[i].ncyc; c++) cyc();
            chk("d0 x",    i, int'(bus0.o_head_x),   vecs[i].x0);
            chk("d0 y",    i, int'(bus0.o_head_y),   vecs[i].y0);
            chk("d0 dir",  i, int'(bus0.o_head_dir), vecs[i].dir0);
            chk("d0 step", i, int'(bus0.o_step),     vecs[i].step0);
            chk("d0 dead", i, int'(bus0.o_dead),     vecs[i].dead0);
            chk("d1 x",    i, int'(bus1.o_head_x),   vecs[i].x1);
            chk("d1 y",    i, int'(bus1.o_head_y),   vecs[i].y1);
            chk("d1 dir",  i, int'(bus1.o_head_dir), vecs[i].dir1);
            chk("d1 step", i, int'(bus1.o_step),     vecs[i].step1);
            chk("d1 dead", i, int'(bus1.o_dead),     vecs[i].dead1);
        end

        // Reset mid-run: the wrap instance is stepping and the wall instance
        // is dead. Both must show reset values with no clock edge in between.
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("async reset mid-run");
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/snake_head_stepper.md
Name: snake_head_stepper

Overview:
- Movement stage directly downstream of the direction/start controller.
- Consumes the controller's registered direction and start flag, generates the game tick, and advances the snake head one grid cell per tick.
- Feeds the committed head direction back to the controller, which uses it to block reversals.
- Publishes the head position, a per-move step pulse and a dead flag to the body/renderer stages.

Parameters:
- X_BITS, 5, width of the X coordinate.
- Y_BITS, 4, width of the Y coordinate.
- GRID_W, 32, number of columns; legal X is 0..GRID_W-1; GRID_W <= 2**X_BITS.
- GRID_H, 16, number of rows; legal Y is 0..GRID_H-1; GRID_H <= 2**Y_BITS.
- START_X, 16, head X after reset or restart.
- START_Y, 2, head Y after reset or restart.
- TICK_PERIOD, 1000000, clocks per move at i_speed=0; must be >= 8.
- WRAP, 0, 1 = wrap at walls, 0 = wall hit kills.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_dir  in  2  requested direction from the controller: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1).
- i_start  in  1  game-start level from the controller.
- i_speed  in  2  tick period = TICK_PERIOD >> i_speed.
- i_kill  in  1  self-collision from the body stage; single-cycle or level.
- i_restart  in  1  leave DEAD.
- o_head_x  out  X_BITS  current head column.
- o_head_y  out  Y_BITS  current head row.
- o_head_dir  out  2  direction of the last committed move; returned to the controller.
- o_step  out  1  one-cycle pulse in the cycle the new head position first appears.
- o_dead  out  1  high while in DEAD.

Behaviour:
Reset (asynchronous, rst_n low): the following values hold until the first clock edge after rst_n rises.
- State IDLE.
- o_head_x = START_X, o_head_y = START_Y.
- o_head_dir = 01. The head points down, so up is the blocked direction.
- Tick counter = 0, o_step = 0, o_dead = 0.

States:
- IDLE: counter held at 0. When i_start=1, go to RUN next cycle.
- RUN: counter increments every cycle.
  - When counter == period-1: counter <= 0 and a tick fires.
  - period is recomputed from i_speed only when the counter wraps, so a speed change never truncates a tick in progress.
- On a tick, with nx/ny = the cell one step in direction i_dir:
  - Legal cell: o_head_x/o_head_y <= nx/ny, o_head_dir <= i_dir, o_step <= 1 for exactly one cycle.
  - Cell off-grid and WRAP=1: the coordinate wraps. x=0 going left becomes GRID_W-1; x=GRID_W-1 going right becomes 0; y wraps the same way with GRID_H. The step is taken normally.
  - Cell off-grid and WRAP=0: position and o_head_dir hold, no o_step, go to DEAD.
- i_kill=1 in RUN, at any cycle: go to DEAD next cycle.
  - If i_kill and a tick coincide, kill wins: no move, no o_step.
- DEAD:
  - o_dead=1; counter held at 0; position and o_head_dir frozen.
  - i_kill and i_start are ignored.
  - i_restart=1: go to IDLE next cycle, with position and direction restored to reset values and o_dead=0.
- Latency: o_step and the new position are registered together, one cycle after the tick condition. o_head_dir changes only on a committed step.
- Coordinate arithmetic is done in X_BITS+1 / Y_BITS+1 bits so that underflow and overflow are detected, never silently truncated.
- i_restart outside DEAD: no effect.
- i_start low in RUN: no effect. The start flag is sticky upstream.

Test Plan:
All scenarios use TICK_PERIOD=8, i_speed=0, GRID 32x16, START (16,2).
- Reset, then i_start=1 with i_dir=01 → RUN; first o_step pulse 9 cycles after i_start (1 cycle to enter RUN, 8-cycle tick); head (16,3), o_head_dir=01; next step 8 cycles later, head (16,4).
- i_dir=10 held, WRAP=0 → x decrements 16..0, one per tick; the next tick sets o_dead=1 with head frozen at (0,2) and no o_step. With WRAP=1 the same tick gives head (31,2) and o_step=1.
- i_kill asserted in the same cycle as a tick → no o_step; o_dead=1 next cycle; position unchanged.
- i_speed changed 0→2 mid-tick → the current tick completes after 8 cycles; the following tick period is 2 cycles.
- In DEAD, pulse i_restart → next cycle IDLE: o_dead=0, head (16,2), o_head_dir=01. rst_n asserted mid-RUN → outputs take reset values immediately, with no clock edge.
